if_id_stage: RTL and testbench

- Fetch stage plus IF/ID pipeline register of the RV32 pipeline.
- Owns the PC and drives the instruction-memory address. Captures the fetched instruction and exposes its rs1/rs2 fields, which feed the load-use hazard detector.
- Consumes that detector's LUHazard as a stall and the EX-stage branch redirect as a flush, inserting NOP bubbles as required.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/if_id_stage.sv | 80 ++++++++
 tb/tb_if_id_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register for the RV32 pipeline.
// Owns the PC, applies flush/stall/memory-wait priority and keeps saturating event counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LUHazard,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [31:0]      IFID_PC,
  output logic [31:0]      IFID_Instr,
  output logic             IFID_Valid,
  output logic [4:0]       IFID_RegisterRs1,
  output logic [4:0]       IFID_RegisterRs2,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0] pcReg;
  logic        flushEvt;
  logic        stallEvt;
  logic        waitEvt;
  logic        advanceEvt;

  // Fixed priority: flush beats stall, stall beats memory wait.
  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    flushEvt   = 1'b0;
    stallEvt   = 1'b0;
    waitEvt    = 1'b0;
    advanceEvt = 1'b0;
    if (branch_taken)     flushEvt   = 1'b1;
    else if (LUHazard)    stallEvt   = 1'b1;
    else if (!imem_ready) waitEvt    = 1'b1;
    else                  advanceEvt = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg      <= RESET_PC;
      IFID_PC    <= 32'h0;
      IFID_Instr <= NOP_INSTR;
      IFID_Valid <= 1'b0;
    end else if (flushEvt || waitEvt) begin
      if (flushEvt) pcReg <= branch_target;
      IFID_PC    <= 32'h0;
      IFID_Instr <= NOP_INSTR;
      IFID_Valid <= 1'b0;
    end else if (advanceEvt) begin
      pcReg      <= pcReg + 32'd4;
      IFID_PC    <= pcReg;
      IFID_Instr <= imem_rdata;
      IFID_Valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stallEvt && stall_count != CNT_MAX) stall_count <= stall_count + 1'b1;
      if (flushEvt && flush_count != CNT_MAX) flush_count <= flush_count + 1'b1;
    end
  end

  assign imem_addr        = pcReg;
  assign IFID_RegisterRs1 = IFID_Instr[19:15];
  assign IFID_RegisterRs2 = IFID_Instr[24:20];

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized traffic against a reference model.
// A second instance with 2-bit counters shares all inputs to exercise saturation.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        LUHazard = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_addr, imem_rdata, IFID_PC, IFID_Instr;
  logic        IFID_Valid;
  logic [4:0]  IFID_RegisterRs1, IFID_RegisterRs2;
  logic [15:0] stall_count, flush_count;

  logic [31:0] sAddr, sPc, sInstr;
  logic        sValid;
  logic [4:0]  sRs1, sRs2;
  logic [1:0]  sStall, sFlush;

  int errors = 0;
  int checks = 0;

  // Reference state: plain counts, saturation applied only when comparing.
  logic [31:0] mPc, mIfPc, mInstr;
  logic        mValid;
  int          mStall, mFlush;

  always #5 clk = ~clk;

  function automatic logic [31:0] memFn(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00A00093;
      32'h4:   return 32'h00108113;
      default: return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endcase
  endfunction

  function automatic logic [31:0] sat(input int c, input int mx);
    return (c > mx) ? mx : c;
  endfunction

  assign imem_rdata = memFn(imem_addr);

  if_id_stage dut (
    .clk(clk), .reset(reset), .LUHazard(LUHazard), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .IFID_PC(IFID_PC), .IFID_Instr(IFID_Instr),
    .IFID_Valid(IFID_Valid), .IFID_RegisterRs1(IFID_RegisterRs1),
    .IFID_RegisterRs2(IFID_RegisterRs2), .stall_count(stall_count), .flush_count(flush_count)
  );

  if_id_stage #(.CNT_W(2)) dutSmall (
    .clk(clk), .reset(reset), .LUHazard(LUHazard), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(sAddr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .IFID_PC(sPc), .IFID_Instr(sInstr),
    .IFID_Valid(sValid), .IFID_RegisterRs1(sRs1),
    .IFID_RegisterRs2(sRs2), .stall_count(sStall), .flush_count(sFlush)
  );

  // Apply one cycle of inputs, advance the reference model across the edge, settle 1 time unit later.
  task automatic drive(input logic rst, input logic lu, input logic bt,
                       input logic [31:0] tgt, input logic rdy);
    reset = rst; LUHazard = lu; branch_taken = bt; branch_target = tgt; imem_ready = rdy;
    @(posedge clk);
    if (rst) begin
      mPc = 32'h0; mIfPc = 32'h0; mInstr = NOP; mValid = 1'b0; mStall = 0; mFlush = 0;
    end else if (bt) begin
      mPc = tgt; mIfPc = 32'h0; mInstr = NOP; mValid = 1'b0; mFlush++;
    end else if (lu) begin
      mStall++;
    end else if (!rdy) begin
      mIfPc = 32'h0; mInstr = NOP; mValid = 1'b0;
    end else begin
      mIfPc = mPc; mInstr = memFn(mPc); mValid = 1'b1; mPc = mPc + 32'd4;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEC, 1'b0);
    checks += 4;
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", imem_addr, 32'h0); end
    if ({IFID_PC, IFID_Instr, IFID_Valid} !== {32'h0, NOP, 1'b0}) begin
      errors++; $display("FAIL reset_ifid: got %h/%h/%b expected 0/%h/0", IFID_PC, IFID_Instr, IFID_Valid, NOP);
    end
    if ({IFID_RegisterRs1, IFID_RegisterRs2} !== 10'h0) begin
      errors++; $display("FAIL reset_rs: got %0d/%0d expected 0/0", IFID_RegisterRs1, IFID_RegisterRs2);
    end
    if ({stall_count, flush_count} !== 32'h0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_count, flush_count);
    end
  endtask

  task automatic test_free_run();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks += 2;
    if (imem_addr !== 32'h4) begin errors++; $display("FAIL run1_addr: got %h expected 4", imem_addr); end
    if ({IFID_PC, IFID_Instr, IFID_Valid} !== {32'h0, 32'h00A00093, 1'b1}) begin
      errors++; $display("FAIL run1_ifid: got %h/%h/%b expected 0/00a00093/1", IFID_PC, IFID_Instr, IFID_Valid);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks += 3;
    if (imem_addr !== 32'h8) begin errors++; $display("FAIL run2_addr: got %h expected 8", imem_addr); end
    if ({IFID_PC, IFID_Instr, IFID_Valid} !== {32'h4, 32'h00108113, 1'b1}) begin
      errors++; $display("FAIL run2_ifid: got %h/%h/%b expected 4/00108113/1", IFID_PC, IFID_Instr, IFID_Valid);
    end
    if (IFID_RegisterRs1 !== 5'd1 || IFID_RegisterRs2 !== 5'd1) begin
      errors++; $display("FAIL run2_rs: got %0d/%0d expected 1/1", IFID_RegisterRs1, IFID_RegisterRs2);
    end
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, (i == 0));
      checks += 2;
      if (imem_addr !== 32'h10) begin errors++; $display("FAIL stall_addr: got %h expected 10", imem_addr); end
      if ({IFID_PC, IFID_Instr, IFID_Valid} !== {32'hC, memFn(32'hC), 1'b1}) begin
        errors++; $display("FAIL stall_hold: got %h/%h/%b expected c/%h/1", IFID_PC, IFID_Instr, IFID_Valid, memFn(32'hC));
      end
    end
    checks++;
    if (stall_count !== 16'd2) begin errors++; $display("FAIL stall_cnt: got %0d expected 2", stall_count); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({IFID_PC, IFID_Instr, IFID_Valid, imem_addr} !== {32'h10, memFn(32'h10), 1'b1, 32'h14}) begin
      errors++; $display("FAIL stall_resume: got %h/%h/%b addr %h expected 10/%h/1 addr 14",
                         IFID_PC, IFID_Instr, IFID_Valid, imem_addr, memFn(32'h10));
    end
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b1, 1'b1, 32'h100, 1'b1);
    checks += 3;
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL flush_addr: got %h expected 100", imem_addr); end
    if ({IFID_PC, IFID_Instr, IFID_Valid} !== {32'h0, NOP, 1'b0}) begin
      errors++; $display("FAIL flush_bubble: got %h/%h/%b expected 0/%h/0", IFID_PC, IFID_Instr, IFID_Valid, NOP);
    end
    if (flush_count !== 16'd1 || stall_count !== 16'd2) begin
      errors++; $display("FAIL flush_cnt: got f=%0d s=%0d expected f=1 s=2", flush_count, stall_count);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({IFID_PC, IFID_Instr, IFID_Valid} !== {32'h100, memFn(32'h100), 1'b1}) begin
      errors++; $display("FAIL flush_target: got %h/%h/%b expected 100/%h/1", IFID_PC, IFID_Instr, IFID_Valid, memFn(32'h100));
    end
  endtask

  task automatic test_mem_wait();
    drive(1'b0, 1'b0, 1'b1, 32'h20, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checks += 3;
      if (imem_addr !== 32'h20) begin errors++; $display("FAIL wait_addr: got %h expected 20", imem_addr); end
      if (IFID_Valid !== 1'b0 || IFID_Instr !== NOP) begin
        errors++; $display("FAIL wait_bubble: got %b/%h expected 0/%h", IFID_Valid, IFID_Instr, NOP);
      end
      if (flush_count !== 16'd2 || stall_count !== 16'd2) begin
        errors++; $display("FAIL wait_cnt: got f=%0d s=%0d expected f=2 s=2", flush_count, stall_count);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({IFID_PC, IFID_Instr, IFID_Valid} !== {32'h20, memFn(32'h20), 1'b1}) begin
      errors++; $display("FAIL wait_resume: got %h/%h/%b expected 20/%h/1", IFID_PC, IFID_Instr, IFID_Valid, memFn(32'h20));
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (imem_addr !== 32'h0 || IFID_PC !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap: got addr %h ifpc %h expected 0/fffffffc", imem_addr, IFID_PC);
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if (sStall !== ((i > 3) ? 2'd3 : 2'(i))) begin
        errors++; $display("FAIL sat_small: cycle %0d got %0d expected %0d", i, sStall, (i > 3) ? 3 : i);
      end
    end
    checks++;
    if (stall_count !== 16'd5) begin errors++; $display("FAIL sat_wide: got %0d expected 5", stall_count); end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
    checks++;
    if (sFlush !== 2'd3 || flush_count !== 16'd4) begin
      errors++; $display("FAIL sat_flush: got %0d/%0d expected 3/4", sFlush, flush_count);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (stall_count !== 16'd4 || imem_addr !== 32'h44) begin
      errors++; $display("FAIL mid_setup: got s=%0d addr %h expected 4/44", stall_count, imem_addr);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    checks += 2;
    if ({imem_addr, IFID_PC, IFID_Instr, IFID_Valid} !== {32'h0, 32'h0, NOP, 1'b0}) begin
      errors++; $display("FAIL mid_reset: got %h/%h/%h/%b expected 0/0/%h/0", imem_addr, IFID_PC, IFID_Instr, IFID_Valid, NOP);
    end
    if ({stall_count, flush_count, sStall, sFlush} !== 36'h0) begin
      errors++; $display("FAIL mid_cnt: got %0d/%0d/%0d/%0d expected all 0", stall_count, flush_count, sStall, sFlush);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({IFID_PC, IFID_Instr, IFID_Valid, stall_count} !== {32'h0, 32'h00A00093, 1'b1, 16'd0}) begin
      errors++; $display("FAIL mid_resume: got %h/%h/%b s=%0d expected 0/00a00093/1 s=0", IFID_PC, IFID_Instr, IFID_Valid, stall_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            tgt, $urandom_range(0, 4) != 0);
      checks += 5;
      if (imem_addr !== mPc || sAddr !== mPc) begin
        errors++; $display("FAIL rnd_addr: cycle %0d got %h/%h expected %h", n, imem_addr, sAddr, mPc);
      end
      if ({IFID_PC, IFID_Instr, IFID_Valid} !== {mIfPc, mInstr, mValid}) begin
        errors++; $display("FAIL rnd_ifid: cycle %0d got %h/%h/%b expected %h/%h/%b",
                           n, IFID_PC, IFID_Instr, IFID_Valid, mIfPc, mInstr, mValid);
      end
      if (IFID_RegisterRs1 !== mInstr[19:15] || IFID_RegisterRs2 !== mInstr[24:20]) begin
        errors++; $display("FAIL rnd_rs: cycle %0d got %0d/%0d expected %0d/%0d",
                           n, IFID_RegisterRs1, IFID_RegisterRs2, mInstr[19:15], mInstr[24:20]);
      end
      if ({16'h0, stall_count} !== sat(mStall, 65535) || {16'h0, flush_count} !== sat(mFlush, 65535)) begin
        errors++; $display("FAIL rnd_cnt: cycle %0d got s=%0d f=%0d expected s=%0d f=%0d", n, stall_count, flush_count, mStall, mFlush);
      end
      if ({30'h0, sStall} !== sat(mStall, 3) || {30'h0, sFlush} !== sat(mFlush, 3)) begin
        errors++; $display("FAIL rnd_small_cnt: cycle %0d got s=%0d f=%0d expected s=%0d f=%0d",
                           n, sStall, sFlush, sat(mStall, 3), sat(mFlush, 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_flush();
    test_mem_wait();
    test_wrap();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
